// File: rtl/sbm_div_pkg.sv
// Shared definitions for the digit-serial restoring divider: FSM encoding
// and helpers that derive counter widths from the block parameters.
package sbm_div_pkg;

   localparam int SIZEA_DEF         = 1024;
   localparam int SIZEOF_DIGITS_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT,
      ST_STORE,
      ST_DONE
   } state_t;

   // Digit counter must be able to hold DIGITS itself.
   function automatic int cnt_w(input int digits);
      return $clog2(digits + 1);
   endfunction

   // Step counter inside the per-digit datapath.
   function automatic int step_w(input int steps);
      return $clog2(steps + 1);
   endfunction

endpackage

// File: rtl/sbm_digitized_div_if.sv
// Request/result bundle of the divider: operands in, quotient/remainder out.
interface sbm_digitized_div_if #(
   parameter int SIZEA = 1024
);
   logic                 start;
   logic [2*SIZEA-1:0]   a;
   logic [SIZEA-1:0]     b;
   logic [2*SIZEA-1:0]   q;
   logic [SIZEA-1:0]     r;
   logic                 busy;
   logic                 done;
   logic                 div_by_zero;

   modport master (output start, a, b,
                   input  q, r, busy, done, div_by_zero);
   modport slave  (input  start, a, b,
                   output q, r, busy, done, div_by_zero);
endinterface

// File: rtl/sbm_digitized_div_div_unit.sv
// Per-digit restoring datapath: consumes one dividend digit MSB-first, one
// bit per cycle, and keeps the running partial remainder across digits.
module div_unit
   import sbm_div_pkg::*;
#(
   parameter int N = SIZEA_DEF,
   parameter int S = SIZEOF_DIGITS_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         start,
   input  logic [S-1:0] digit,
   input  logic [N-1:0] b,
   output logic [S-1:0] qbits,
   output logic [N-1:0] rem,
   output logic         done
);
   localparam int SW = step_w(S);

   logic [S-1:0]  dig;
   logic [SW-1:0] step;
   logic          run;
   logic [N:0]    rem_sh;
   logic [N:0]    rem_nx;
   logic          ge;

   // One restoring step: shift in the next bit, subtract when it fits.
   // rem_nx is always < b, so the stored remainder needs only N bits.
   always_comb begin
      rem_sh = {rem, dig[S-1]};
      ge     = (rem_sh >= {1'b0, b});
      rem_nx = ge ? (rem_sh - {1'b0, b}) : rem_sh;
   end

   // High during the last step of the digit, so the caller can leave its
   // wait state on the same edge the final quotient bit lands.
   assign done = run && (step == SW'(S - 1));

   // Step sequencing and partial remainder / quotient-bit registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dig   <= '0;
         step  <= '0;
         run   <= 1'b0;
         rem   <= '0;
         qbits <= '0;
      end else if (clr) begin
         rem   <= '0;
         qbits <= '0;
         run   <= 1'b0;
      end else if (start) begin
         dig  <= digit;
         step <= '0;
         run  <= 1'b1;
      end else if (run) begin
         rem   <= rem_nx[N-1:0];
         qbits <= (qbits << 1) | S'(ge);
         dig   <= dig << 1;
         step  <= step + 1'b1;
         if (done) run <= 1'b0;
      end
   end

endmodule

// File: rtl/sbm_digitized_div.sv
// Digit-serial 2N/N restoring divider: sequences div_unit over DIGITS
// dividend digits and assembles the quotient.
module sbm_digitized_div
   import sbm_div_pkg::*;
#(
   parameter int SIZEA         = SIZEA_DEF,
   parameter int SIZEOF_DIGITS = SIZEOF_DIGITS_DEF,
   parameter int DIGITS        = 2 * SIZEA / SIZEOF_DIGITS
) (
   input  logic                clk,
   input  logic                rst,
   sbm_digitized_div_if.slave  bus
);
   localparam int N  = SIZEA;
   localparam int S  = SIZEOF_DIGITS;
   localparam int CW = cnt_w(DIGITS);

   state_t          st;
   logic [2*N-1:0]  a_sh;
   logic [2*N-1:0]  q_int;
   logic [2*N+S-1:0] q_cat;
   logic [N-1:0]    b_l;
   logic [CW-1:0]   cnt;

   logic            u_clr;
   logic            u_start;
   logic [S-1:0]    u_qbits;
   logic [N-1:0]    u_rem;
   logic            u_done;

   // The dividend is shifted left per digit, so the current digit is
   // always the top S bits.
   assign u_clr   = (st == ST_IDLE) && bus.start;
   assign u_start = (st == ST_LOAD);
   assign q_cat   = {q_int, u_qbits};

   div_unit #(.N(N), .S(S)) u_div (
      .clk   (clk),
      .rst   (rst),
      .clr   (u_clr),
      .start (u_start),
      .digit (a_sh[2*N-1 -: S]),
      .b     (b_l),
      .qbits (u_qbits),
      .rem   (u_rem),
      .done  (u_done)
   );

   // Control FSM with registered result outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st              <= ST_IDLE;
         a_sh            <= '0;
         q_int           <= '0;
         b_l             <= '0;
         cnt             <= '0;
         bus.q           <= '0;
         bus.r           <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.div_by_zero <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (st)
            ST_IDLE: if (bus.start) begin
               a_sh            <= bus.a;
               b_l             <= bus.b;
               q_int           <= '0;
               cnt             <= '0;
               bus.busy        <= 1'b1;
               bus.div_by_zero <= 1'b0;
               st              <= (bus.b == '0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD:  st <= ST_WAIT;
            ST_WAIT:  if (u_done) st <= ST_STORE;
            ST_STORE: begin
               q_int <= q_cat[2*N-1:0];
               a_sh  <= a_sh << S;
               cnt   <= cnt + 1'b1;
               st    <= (cnt == CW'(DIGITS - 1)) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               if (b_l == '0) begin
                  bus.q           <= '1;
                  bus.r           <= '0;
                  bus.div_by_zero <= 1'b1;
               end else begin
                  bus.q           <= q_int;
                  bus.r           <= u_rem;
                  bus.div_by_zero <= 1'b0;
               end
               st <= ST_IDLE;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sbm_digitized_div.sv
// Directed bench for sbm_digitized_div at SIZEA=16, 8-bit digits.
module tb_sbm_digitized_div;

   logic clk;
   logic rst;
   int   nchk;
   int   nerr;

   sbm_digitized_div_if #(.SIZEA(16)) bus ();

   sbm_digitized_div #(.SIZEA(16), .SIZEOF_DIGITS(8), .DIGITS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT idle. Launches a division, optionally
   // re-pulses start at cycle 'poke' with other operands, and checks the
   // result and the done latency (edges after the accept edge).
   task automatic do_div(input string tag, input logic [31:0] av, input logic [15:0] bv,
                         input logic [31:0] eq, input logic [15:0] er, input logic edz,
                         input int elat, input int poke);
      int n;
      bit seen;
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      n    = 0;
      seen = 0;
      chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
      chk({tag, "_dbz_clr"}, 64'(bus.div_by_zero), 64'd0);
      while (n <= 100) begin
         if (bus.done) begin
            seen = 1;
            break;
         end
         if (n == poke) begin
            bus.start = 1'b1;
            bus.a     = 32'd999;
            bus.b     = 16'd3;
         end
         if (n == poke + 1) bus.start = 1'b0;
         @(negedge clk);
         n++;
      end
      bus.start = 1'b0;
      chk({tag, "_seen"}, 64'(seen), 64'd1);
      chk({tag, "_lat"}, 64'(n), 64'(elat));
      chk({tag, "_q"}, 64'(bus.q), 64'(eq));
      chk({tag, "_r"}, 64'(bus.r), 64'(er));
      chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(edz));
      chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      bit seen;
      nchk      = 0;
      nerr      = 0;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      chk("rst_q", 64'(bus.q), 64'd0);
      chk("rst_r", 64'(bus.r), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      do_div("d1000_7", 32'd1000, 16'd7, 32'd142, 16'd6, 1'b0, 41, -10);
      do_div("poke", 32'd1000, 16'd7, 32'd142, 16'd6, 1'b0, 41, 10);
      do_div("max", 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'd0, 1'b0, 41, -10);
      do_div("d5_9", 32'd5, 16'd9, 32'd0, 16'd5, 1'b0, 41, -10);
      // Issued in the done cycle itself: accepted on the very next edge.
      do_div("same", 32'h0000_1234, 16'h1234, 32'd1, 16'd0, 1'b0, 41, -10);
      do_div("dbz", 32'd123, 16'd0, 32'hFFFF_FFFF, 16'd0, 1'b1, 1, -10);

      @(negedge clk);
      chk("hold_q", 64'(bus.q), 64'hFFFF_FFFF);
      chk("hold_dbz", 64'(bus.div_by_zero), 64'd1);
      chk("hold_done", 64'(bus.done), 64'd0);

      // Abort a running division with reset.
      bus.start = 1'b1;
      bus.a     = 32'd1000;
      bus.b     = 16'd7;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_done", 64'(bus.done), 64'd0);
      chk("abort_q", 64'(bus.q), 64'd0);
      chk("abort_dbz", 64'(bus.div_by_zero), 64'd0);
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done) seen = 1;
      end
      rst = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (bus.done) seen = 1;
      end
      chk("abort_nodone", 64'(seen), 64'd0);

      do_div("after", 32'd1000, 16'd7, 32'd142, 16'd6, 1'b0, 41, -10);
      do_div("d65535_256", 32'd65535, 16'd256, 32'd255, 16'd255, 1'b0, 41, -10);

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule
